// File: rtl/flags_stack_reg.sv
// Flag register with masked ALU updates, software load, single-bit set/clear,
// and a small save/restore stack that reports sticky overflow and underflow errors.
module flags_stack_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       alu_en,
  input  logic [WIDTH-1:0]           alu_mask,
  input  logic [WIDTH-1:0]           alu_flags,
  input  logic                       ld,
  input  logic [WIDTH-1:0]           ld_val,
  input  logic                       set_en,
  input  logic                       clr_en,
  input  logic [$clog2(WIDTH)-1:0]   bit_idx,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           flags,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             bit_ok;
  logic             pop_ok;
  logic             swap;
  logic             push_ok;
  logic             stack_we;
  logic             ovf_set;
  logic             unf_set;
  logic [WIDTH-1:0] flags_nxt;
  logic [CW-1:0]    depth_nxt;

  // Out-of-range indices only exist when WIDTH is not a power of two.
  generate
    if (WIDTH == (1 << IW)) begin : g_idx_full
      assign bit_ok = 1'b1;
    end else begin : g_idx_part
      assign bit_ok = bit_idx < IW'(WIDTH);
    end
  endgenerate

  assign full    = depth_cnt == CW'(DEPTH);
  assign empty   = depth_cnt == '0;
  assign top_idx = AW'(depth_cnt - CW'(1));

  always_comb begin
    pop_ok    = pop && !empty;
    swap      = push && pop_ok;
    push_ok   = push && !pop_ok && !full;
    stack_we  = swap || push_ok;
    wr_idx    = swap ? top_idx : AW'(depth_cnt);
    ovf_set   = push && !pop_ok && full;
    unf_set   = pop && empty;
    depth_nxt = depth_cnt;
    if (push_ok) begin
      depth_nxt = depth_cnt + CW'(1);
    end else if (pop_ok && !swap) begin
      depth_nxt = depth_cnt - CW'(1);
    end

    // Only the highest-priority active source touches the flags.
    flags_nxt = flags;
    if (pop_ok) begin
      flags_nxt = stack[top_idx];
    end else if (ld) begin
      flags_nxt = ld_val;
    end else if ((set_en || clr_en) && bit_ok) begin
      flags_nxt[bit_idx] = set_en;
    end else if (alu_en) begin
      flags_nxt = (flags & ~alu_mask) | (alu_flags & alu_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      flags     <= RST_VAL;
      depth_cnt <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      flags     <= flags_nxt;
      depth_cnt <= depth_nxt;
      ovf_err   <= ovf_set | (ovf_err & ~err_clr);
      unf_err   <= unf_set | (unf_err & ~err_clr);
    end
  end

  // Stack storage needs no reset; entries above depth_cnt are never read.
  always_ff @(posedge clk) begin
    if (stack_we) begin
      stack[wr_idx] <= flags;
    end
  end

endmodule

// File: tb/tb_flags_stack_reg.sv
// Scoreboard bench for flags_stack_reg: a reference model predicts each cycle's
// outputs, queues them, and they are compared after the clock edge.
module tb_flags_stack_reg;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int EW = W + 3 + 4;

  logic         clk;
  logic         rst_b;
  logic         alu_en;
  logic [W-1:0] alu_mask;
  logic [W-1:0] alu_flags;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         set_en;
  logic         clr_en;
  logic [3:0]   bit_idx;
  logic         push;
  logic         pop;
  logic         err_clr;
  logic [W-1:0] flags;
  logic [2:0]   depth_cnt;
  logic         full;
  logic         empty;
  logic         ovf_err;
  logic         unf_err;

  flags_stack_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(16'h0000)) dut (
    .clk(clk), .rst_b(rst_b), .alu_en(alu_en), .alu_mask(alu_mask),
    .alu_flags(alu_flags), .ld(ld), .ld_val(ld_val), .set_en(set_en),
    .clr_en(clr_en), .bit_idx(bit_idx), .push(push), .pop(pop),
    .err_clr(err_clr), .flags(flags), .depth_cnt(depth_cnt), .full(full),
    .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [W-1:0] m_flags;
  logic [W-1:0] m_stack [D];
  int           m_depth;
  logic         m_ovf;
  logic         m_unf;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_en = 0; alu_mask = '0; alu_flags = '0; ld = 0; ld_val = '0;
    set_en = 0; clr_en = 0; bit_idx = '0; push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic model_reset();
    m_flags = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Reference behaviour, written case by case from the stack operation outward.
  task automatic model_step();
    logic [W-1:0] nf;
    logic         new_ovf, new_unf;
    nf = m_flags;
    new_ovf = 0;
    new_unf = 0;
    if (pop && m_depth > 0) nf = m_stack[m_depth-1];
    else if (ld) nf = ld_val;
    else if ((set_en || clr_en) && int'(bit_idx) < W) nf[bit_idx] = set_en ? 1'b1 : 1'b0;
    else if (alu_en) begin
      for (int i = 0; i < W; i++) if (alu_mask[i]) nf[i] = alu_flags[i];
    end
    if (push && pop) begin
      if (m_depth > 0) m_stack[m_depth-1] = m_flags;
      else begin
        m_stack[0] = m_flags;
        m_depth = 1;
        new_unf = 1;
      end
    end else if (push) begin
      if (m_depth < D) begin
        m_stack[m_depth] = m_flags;
        m_depth++;
      end else new_ovf = 1;
    end else if (pop) begin
      if (m_depth > 0) m_depth--;
      else new_unf = 1;
    end
    m_ovf = new_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
    m_unf = new_unf ? 1'b1 : (err_clr ? 1'b0 : m_unf);
    m_flags = nf;
  endtask

  // Drive one cycle: predict, queue, clock, pop and compare.
  task automatic step(input string tag);
    logic [EW-1:0] e;
    model_step();
    exp_q.push_back({m_flags, 3'(m_depth), m_depth == D, m_depth == 0, m_ovf, m_unf});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".flags"}, 32'(flags), 32'(e[EW-1:7]));
    check({tag, ".depth"}, 32'(depth_cnt), 32'(e[6:4]));
    check({tag, ".full"},  32'(full),  32'(e[3]));
    check({tag, ".empty"}, 32'(empty), 32'(e[2]));
    check({tag, ".ovf"},   32'(ovf_err), 32'(e[1]));
    check({tag, ".unf"},   32'(unf_err), 32'(e[0]));
    idle_inputs();
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'h0);
    check({tag, ".depth"}, 32'(depth_cnt), 32'h0);
    check({tag, ".full"},  32'(full), 32'h0);
    check({tag, ".empty"}, 32'(empty), 32'h1);
    check({tag, ".ovf"},   32'(ovf_err), 32'h0);
    check({tag, ".unf"},   32'(unf_err), 32'h0);
  endtask

  initial begin
    reset_dut();
    check_reset_outputs("rst");

    // masked ALU update
    alu_en = 1; alu_mask = 16'h000F; alu_flags = 16'hFFFF;
    step("alu_mask");
    check("alu_val", 32'(flags), 32'h000F);

    // ld beats set_en and alu_en
    ld = 1; ld_val = 16'h00F0; step("ld_f0");
    ld = 1; ld_val = 16'h1234; set_en = 1; bit_idx = 4'd0; alu_en = 1;
    alu_mask = 16'hFFFF; alu_flags = 16'hFFFF;
    step("prio");
    check("prio_val", 32'(flags), 32'h1234);

    // set beats clr, then clear alone
    set_en = 1; clr_en = 1; bit_idx = 4'd15; step("set_clr");
    clr_en = 1; bit_idx = 4'd4; step("clr");

    // fill past full, then drain
    for (int i = 1; i <= 5; i++) begin
      ld = 1; ld_val = 16'(i); step("ld_seq");
      push = 1; step("push_seq");
    end
    check("full_ovf", 32'({full, ovf_err, depth_cnt}), 32'({1'b1, 1'b1, 3'd4}));
    for (int i = 4; i >= 1; i--) begin
      pop = 1; step("pop_seq");
      check("pop_val", 32'(flags), 32'(i));
    end
    check("drained", 32'(empty), 32'h1);

    // pop on empty falls through to clr_en
    ld = 1; ld_val = 16'h0008; step("ld_08");
    pop = 1; clr_en = 1; bit_idx = 4'd3; step("pop_empty");
    check("pop_empty_val", 32'({flags, unf_err}), 32'({16'h0000, 1'b1}));
    err_clr = 1; step("err_clr");
    check("err_clr_val", 32'({ovf_err, unf_err}), 32'h0);

    // swap
    ld = 1; ld_val = 16'hAAAA; step("ld_aa");
    push = 1; step("push_aa");
    ld = 1; ld_val = 16'h5555; step("ld_55");
    push = 1; pop = 1; step("swap");
    check("swap_val", 32'({flags, depth_cnt}), 32'({16'hAAAA, 3'd1}));
    pop = 1; step("swap_top");
    check("swap_top_val", 32'(flags), 32'h5555);

    // push+pop on empty pushes and flags underflow; new error beats err_clr
    push = 1; pop = 1; err_clr = 1; step("pp_empty");

    // asynchronous reset between edges with depth 2 and ovf set
    for (int i = 0; i < 4; i++) begin push = 1; step("fill"); end
    push = 1; step("ovf");
    pop = 1; step("pop_a");
    pop = 1; step("pop_b");
    #2;
    push = 1; rst_b = 0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1;
    rst_b = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    check_reset_outputs("post_rst");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      alu_en    = ($urandom_range(0, 3) == 0);
      alu_mask  = 16'($urandom_range(0, 16'hFFFF));
      alu_flags = 16'($urandom_range(0, 16'hFFFF));
      ld        = ($urandom_range(0, 7) == 0);
      ld_val    = 16'($urandom_range(0, 16'hFFFF));
      set_en    = ($urandom_range(0, 5) == 0);
      clr_en    = ($urandom_range(0, 5) == 0);
      bit_idx   = 4'($urandom_range(0, 15));
      push      = ($urandom_range(0, 2) == 0);
      pop       = ($urandom_range(0, 2) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flags_stack_reg.md
FLAGS_STACK_REG -- requirements
Module: flags_stack_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of flag bits (2..32).
REQ-002 SHALL have parameter DEPTH, default 4: save/restore stack entries (1..16).
REQ-003 SHALL have parameter RST_VAL, default 0: flags value after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port alu_en  input  1  ALU flag-update strobe.
REQ-007 SHALL have port alu_mask  input  WIDTH  bits the ALU update may change.
REQ-008 SHALL have port alu_flags  input  WIDTH  new ALU flag values.
REQ-009 SHALL have port ld  input  1  full software load strobe.
REQ-010 SHALL have port ld_val  input  WIDTH  value for ld.
REQ-011 SHALL have ports set_en and clr_en  input  1 each  single-bit set and clear strobes.
REQ-012 SHALL have port bit_idx  input  clog2(WIDTH)  bit index for set_en/clr_en.
REQ-013 SHALL have ports push and pop  input  1 each  save/restore strobes.
REQ-014 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-015 SHALL have port flags  output  WIDTH  current flag register.
REQ-016 SHALL have port depth_cnt  output  clog2(DEPTH+1)  occupied stack entries.
REQ-017 SHALL have ports full and empty  output  1 each  depth_cnt==DEPTH and depth_cnt==0.
REQ-018 SHALL have ports ovf_err and unf_err  output  1 each  sticky push-overflow and pop-underflow.

Function
REQ-019 SHALL register flags; every update SHALL be visible on flags one cycle after the sampling edge.
REQ-020 SHALL apply flag-source priority pop(valid) > ld > set_en/clr_en > alu_en; only the highest active source SHALL modify flags in a cycle.
REQ-021 SHALL, on alu_en, load flags[i] from alu_flags[i] where alu_mask[i]=1 and hold the other bits.
REQ-022 SHALL, on set_en, set flags[bit_idx]; on clr_en, clear it; with both asserted, set SHALL win.
REQ-023 SHALL ignore set_en/clr_en when bit_idx >= WIDTH; lower-priority alu_en SHALL then apply.
REQ-024 SHALL, on push with not full, write the pre-edge flags value to stack[depth_cnt] and increment depth_cnt; flag updates in that cycle SHALL still apply.
REQ-025 SHALL, on push with full, drop the push, leave stack and depth_cnt unchanged, and set ovf_err.
REQ-026 SHALL, on pop with not empty, load flags from the top entry and decrement depth_cnt.
REQ-027 SHALL, on pop with empty, leave flags to lower-priority sources, leave depth_cnt at 0, and set unf_err.
REQ-028 SHALL, on push and pop with not empty, swap: flags <= top entry, top entry <= pre-edge flags, depth_cnt unchanged.
REQ-029 SHALL, on push and pop with empty, perform the push per REQ-024 and set unf_err.
REQ-030 SHALL drive full and empty combinationally from depth_cnt.
REQ-031 SHALL clear ovf_err/unf_err on err_clr; a new error in the same cycle SHALL win over err_clr.

Reset
REQ-032 SHALL, when rst_b=0, asynchronously force flags=RST_VAL, depth_cnt=0, ovf_err=0, unf_err=0, empty=1, full=0, independent of clk.
REQ-033 SHALL not need to clear stack contents on reset; they SHALL be unobservable until pushed.
REQ-034 SHALL accept all strobes from the first rising edge after rst_b deasserts; reset mid-push/pop SHALL leave the reset state.

Verification
REQ-035 SHALL cover: WIDTH=16, flags=0x0000, alu_en, alu_mask=0x000F, alu_flags=0xFFFF -> flags=0x000F next cycle.
REQ-036 SHALL cover: flags=0x00F0, ld=1 (ld_val=0x1234), set_en=1, alu_en=1 same cycle -> flags=0x1234.
REQ-037 SHALL cover: DEPTH=4, five pushes of 0x1,0x2,0x3,0x4,0x5 -> depth_cnt=4, full=1, ovf_err=1; four pops -> flags 0x4,0x3,0x2,0x1, empty=1.
REQ-038 SHALL cover: empty stack, pop with clr_en, bit_idx=3, flags=0x0008 -> flags=0x0000, unf_err=1; err_clr -> unf_err=0.
REQ-039 SHALL cover: depth_cnt=1, top=0xAAAA, flags=0x5555, push+pop -> flags=0xAAAA, top=0x5555, depth_cnt=1.
REQ-040 SHALL cover: depth_cnt=2, ovf_err=1, rst_b pulsed low between edges -> flags=RST_VAL, depth_cnt=0, ovf_err=0 immediately.
